// File: rtl/delay_calc_pkg.sv
// Shared state encoding and sizing helpers for the multi-channel delay calculator.
package delay_calc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DIFF   = 3'd1,
    SQUARE = 3'd2,
    SUM    = 3'd3,
    ROOT   = 3'd4,
    RESULT = 3'd5,
    OUT    = 3'd6,
    DONE   = 3'd7
  } state_t;

  // Radicand width: two squared (COORD_W+1)-bit terms plus carry, padded to an even width.
  function automatic int sum_width(input int coord_w);
    return 32'sd2 * coord_w + 32'sd4;
  endfunction

  function automatic longint unsigned sat_max(input int delay_w);
    return (64'd1 << delay_w) - 64'd1;
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Sequential non-restoring integer square root, one result bit per clock.
// The first bit resolves on the start edge, so valid pulses IN_W/2 cycles after start.
module isqrt_seq #(
  parameter int IN_W = 36
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IN_W-1:0]   din,
  output logic [IN_W/2-1:0] dout,
  output logic              valid
);

  localparam int HALF  = IN_W / 2;
  localparam int CNT_W = $clog2(HALF + 1);

  logic [HALF+1:0]  rem_r;
  logic [HALF-1:0]  root_r;
  logic [IN_W-1:0]  rad_r;
  logic [CNT_W-1:0] cnt_r;
  logic             run_r;

  logic [HALF+1:0]  rem_in_s;
  logic [HALF+1:0]  rem_sh_s;
  logic [HALF+1:0]  trial_s;
  logic [HALF+1:0]  rem_next_s;
  logic [HALF-1:0]  root_in_s;
  logic [HALF-1:0]  root_next_s;
  logic [IN_W-1:0]  rad_in_s;

  // One iteration; the remainder is kept modulo 2^(HALF+2), its MSB is the sign.
  always_comb begin
    if (start) begin
      rem_in_s  = '0;
      root_in_s = '0;
      rad_in_s  = din;
    end else begin
      rem_in_s  = rem_r;
      root_in_s = root_r;
      rad_in_s  = rad_r;
    end
    rem_sh_s = {rem_in_s[HALF-1:0], rad_in_s[IN_W-1 -: 2]};
    if (rem_in_s[HALF+1]) begin
      trial_s    = {root_in_s, 2'b11};
      rem_next_s = rem_sh_s + trial_s;
    end else begin
      trial_s    = {root_in_s, 2'b01};
      rem_next_s = rem_sh_s - trial_s;
    end
    root_next_s = {root_in_s[HALF-2:0], ~rem_next_s[HALF+1]};
  end

  // Iteration state, result capture and the one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r  <= '0;
      root_r <= '0;
      rad_r  <= '0;
      cnt_r  <= '0;
      run_r  <= 1'b0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        rem_r  <= rem_next_s;
        root_r <= root_next_s;
        rad_r  <= {rad_in_s[IN_W-3:0], 2'b00};
        cnt_r  <= CNT_W'(HALF - 1);
        run_r  <= 1'b1;
      end else if (run_r) begin
        rem_r  <= rem_next_s;
        root_r <= root_next_s;
        rad_r  <= {rad_in_s[IN_W-3:0], 2'b00};
        cnt_r  <= cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          run_r <= 1'b0;
          valid <= 1'b1;
          dout  <= root_next_s;
        end
      end
    end
  end

endmodule

// File: rtl/delay_calc_array.sv
// Multi-channel receive-path delay calculator: one sqrt per element, results
// streamed to the beamformer delay table over valid/ready.
module delay_calc_array
  import delay_calc_pkg::*;
#(
  parameter int NUM_CH  = 16,
  parameter int COORD_W = 16,
  parameter int DELAY_W = 12,
  parameter int CH_W    = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] x_f,
  input  logic [COORD_W-1:0] z_f,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] pitch,
  input  logic               tx_mode,
  output logic [DELAY_W-1:0] delay_out,
  output logic [CH_W-1:0]    delay_ch,
  output logic               delay_valid,
  input  logic               delay_ready,
  output logic               sat,
  output logic               busy,
  output logic               done
);

  localparam int S_W  = sum_width(COORD_W);
  localparam int R_W  = S_W / 2;
  localparam int T_W  = R_W + 1;
  localparam int D_W  = COORD_W + 1;
  localparam int SQ_W = 2 * COORD_W + 2;
  localparam longint unsigned SAT_MAX = sat_max(DELAY_W);

  state_t              state_r;
  logic [COORD_W-1:0]  xf_r;
  logic [COORD_W-1:0]  zf_r;
  logic [COORD_W-1:0]  xe_r;
  logic [COORD_W-1:0]  pitch_r;
  logic                tx_r;
  logic [CH_W-1:0]     ch_r;
  logic signed [D_W-1:0] dx_r;
  logic signed [D_W-1:0] dz_r;
  logic [SQ_W-1:0]     dx2_r;
  logic [SQ_W-1:0]     dz2_r;

  logic signed [SQ_W-1:0] dx_sq_s;
  logic signed [SQ_W-1:0] dz_sq_s;
  logic [S_W-1:0]      sum_s;
  logic                root_start_s;
  logic [R_W-1:0]      root_s;
  logic                root_valid_s;
  logic [T_W-1:0]      total_s;

  // The root is launched with the sum so ROOT lasts exactly the core latency.
  always_comb begin
    dx_sq_s      = SQ_W'(dx_r) * SQ_W'(dx_r);
    dz_sq_s      = SQ_W'(dz_r) * SQ_W'(dz_r);
    sum_s        = S_W'(dx2_r) + S_W'(dz2_r);
    root_start_s = (state_r == SUM);
    if (tx_r) begin
      total_s = T_W'(root_s) + T_W'(zf_r);
    end else begin
      total_s = T_W'(root_s);
    end
  end

  isqrt_seq #(
    .IN_W (S_W)
  ) u_root (
    .clk   (clk),
    .reset (reset),
    .start (root_start_s),
    .din   (sum_s),
    .dout  (root_s),
    .valid (root_valid_s)
  );

  // Frame sequencer: per-channel datapath steps and the output handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      xf_r        <= '0;
      zf_r        <= '0;
      xe_r        <= '0;
      pitch_r     <= '0;
      tx_r        <= 1'b0;
      ch_r        <= '0;
      dx_r        <= '0;
      dz_r        <= '0;
      dx2_r       <= '0;
      dz2_r       <= '0;
      delay_out   <= '0;
      delay_ch    <= '0;
      delay_valid <= 1'b0;
      sat         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            xf_r    <= x_f;
            zf_r    <= z_f;
            pitch_r <= pitch;
            tx_r    <= tx_mode;
            xe_r    <= x0;
            ch_r    <= '0;
            busy    <= 1'b1;
            state_r <= DIFF;
          end
        end
        DIFF: begin
          dx_r    <= {xe_r[COORD_W-1], xe_r} - {xf_r[COORD_W-1], xf_r};
          dz_r    <= {zf_r[COORD_W-1], zf_r};
          state_r <= SQUARE;
        end
        SQUARE: begin
          dx2_r   <= $unsigned(dx_sq_s);
          dz2_r   <= $unsigned(dz_sq_s);
          state_r <= SUM;
        end
        SUM: begin
          state_r <= ROOT;
        end
        ROOT: begin
          if (root_valid_s) begin
            state_r <= RESULT;
          end
        end
        RESULT: begin
          if (64'(total_s) > SAT_MAX) begin
            delay_out <= '1;
            sat       <= 1'b1;
          end else begin
            delay_out <= total_s[DELAY_W-1:0];
            sat       <= 1'b0;
          end
          delay_ch    <= ch_r;
          delay_valid <= 1'b1;
          state_r     <= OUT;
        end
        OUT: begin
          if (delay_ready) begin
            delay_valid <= 1'b0;
            if (ch_r == CH_W'(NUM_CH - 1)) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              ch_r    <= ch_r + CH_W'(1);
              xe_r    <= xe_r + pitch_r;
              state_r <= DIFF;
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          delay_valid <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_calc_array.sv
// Directed and randomized bench for delay_calc_array (4 channels, 8-bit delays)
// and a standalone 36-bit isqrt_seq, checked against an arithmetic reference.
module tb_delay_calc_array;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] x_f, z_f, x0, pitch;
  logic        tx_mode;
  logic [7:0]  delay_out;
  logic [1:0]  delay_ch;
  logic        delay_valid, delay_ready, sat, busy, done;

  logic        sq_start;
  logic [35:0] sq_din;
  logic [17:0] sq_dout;
  logic        sq_valid;

  int checks = 0;
  int errors = 0;

  delay_calc_array #(.NUM_CH(NCH), .COORD_W(16), .DELAY_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .x_f(x_f), .z_f(z_f), .x0(x0),
    .pitch(pitch), .tx_mode(tx_mode), .delay_out(delay_out), .delay_ch(delay_ch),
    .delay_valid(delay_valid), .delay_ready(delay_ready), .sat(sat), .busy(busy),
    .done(done)
  );

  isqrt_seq #(.IN_W(36)) u_sq (
    .clk(clk), .reset(reset), .start(sq_start), .din(sq_din), .dout(sq_dout),
    .valid(sq_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint unsigned isqrt_ref(input longint unsigned v);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 20;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // Element c sits at x0 + c*pitch (16-bit wrap); delay = floor(dist) (+ z_f), clamped to 255.
  function automatic void ref_channel(input int x0v, input int pv, input int xfv, input int zfv,
                                      input int txv, input int c, output int dval, output bit sv);
    shortint xe;
    longint  dx, s, tot;
    xe   = shortint'(x0v + c * pv);
    dx   = longint'(xe) - longint'(xfv);
    s    = dx * dx + longint'(zfv) * longint'(zfv);
    tot  = longint'(isqrt_ref(s)) + (txv != 0 ? longint'(zfv) : 0);
    sv   = (tot > 255);
    dval = sv ? 255 : int'(tot);
  endfunction

  task automatic sq_case(input logic [35:0] v, input logic [17:0] e);
    int n;
    sq_din   = v;
    sq_start = 1'b1;
    tick();
    sq_start = 1'b0;
    n = 1;
    while (!sq_valid && n < 40) begin
      tick();
      n++;
    end
    chk($sformatf("sqrt_lat_%0d", v), n, 18);
    chk($sformatf("sqrt_val_%0d", v), sq_dout, e);
    tick();
    chk("sqrt_pulse", sq_valid, 0);
  endtask

  task automatic run_frame(input string name, input int x0v, input int pv, input int xfv,
                           input int zfv, input int txv, input int bp_ch, input int glitch_ch);
    int exp_d[NCH];
    bit exp_s[NCH];
    int n, quiet;
    logic [63:0] held;
    for (int c = 0; c < NCH; c++) ref_channel(x0v, pv, xfv, zfv, txv, c, exp_d[c], exp_s[c]);
    x0 = 16'(x0v); pitch = 16'(pv); x_f = 16'(xfv); z_f = 16'(zfv); tx_mode = txv[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, ".busy_start"}, busy, 1);
    x0 = 16'($urandom); pitch = 16'($urandom); x_f = 16'($urandom); z_f = 16'($urandom);
    tx_mode = 1'($urandom);
    for (int c = 0; c < NCH; c++) begin
      delay_ready = (c != bp_ch);
      n = 1;
      while (!delay_valid && n < 60) begin
        start = (c == glitch_ch && n == 5);
        tick();
        n++;
      end
      start = 1'b0;
      chk($sformatf("%s.ch%0d.lat", name, c), n, 23);
      chk($sformatf("%s.ch%0d.ch", name, c), delay_ch, c);
      chk($sformatf("%s.ch%0d.out", name, c), delay_out, exp_d[c]);
      chk($sformatf("%s.ch%0d.sat", name, c), sat, exp_s[c]);
      chk($sformatf("%s.ch%0d.busy", name, c), busy, 1);
      if (c == bp_ch) begin
        held = 64'({delay_out, delay_ch, sat, delay_valid});
        repeat (5) begin
          tick();
          chk($sformatf("%s.ch%0d.hold", name, c), 64'({delay_out, delay_ch, sat, delay_valid}), held);
        end
        delay_ready = 1'b1;
      end
      tick();
    end
    chk({name, ".done"}, done, 1);
    chk({name, ".busy_end"}, busy, 0);
    tick();
    chk({name, ".done_pulse"}, done, 0);
    quiet = 0;
    repeat (25) begin
      tick();
      if (delay_valid || done || busy) quiet++;
    end
    chk({name, ".quiet"}, quiet, 0);
  endtask

  initial begin
    int n, quiet;
    logic [35:0] rv;
    reset = 1'b1; start = 1'b0; delay_ready = 1'b1; sq_start = 1'b0; sq_din = '0;
    x_f = '0; z_f = '0; x0 = '0; pitch = '0; tx_mode = 1'b0;
    repeat (3) tick();
    chk("rst.out", delay_out, 0);
    chk("rst.ch", delay_ch, 0);
    chk("rst.valid", delay_valid, 0);
    chk("rst.sat", sat, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    reset = 1'b0;
    tick();

    sq_case(36'd0, 18'd0);
    sq_case(36'd1, 18'd1);
    sq_case(36'd24, 18'd4);
    sq_case(36'd25, 18'd5);
    sq_case(36'h3_FFFF_FFFF, 18'd131071);
    repeat (4) begin
      rv = {4'($urandom), 32'($urandom)};
      sq_case(rv, 18'(isqrt_ref(64'(rv))));
    end

    run_frame("rx", -3, 2, 0, 4, 0, -1, -1);
    run_frame("tx", -3, 2, 0, 4, 1, -1, -1);
    run_frame("satur", 0, 0, 0, 300, 0, -1, -1);
    run_frame("bp_glitch", -3, 2, 0, 4, 0, 1, 2);

    // Abort a frame in the middle of channel 1's root extraction.
    x0 = 16'(-3); pitch = 16'd2; x_f = 16'd0; z_f = 16'd4; tx_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!delay_valid && n < 60) begin
      tick();
      n++;
    end
    chk("abort.ch0_lat", n, 23);
    tick();
    repeat (9) tick();
    reset = 1'b1;
    tick();
    chk("abort.out", delay_out, 0);
    chk("abort.ch", delay_ch, 0);
    chk("abort.valid", delay_valid, 0);
    chk("abort.sat", sat, 0);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    reset = 1'b0;
    quiet = 0;
    repeat (40) begin
      tick();
      if (delay_valid || done || busy) quiet++;
    end
    chk("abort.quiet", quiet, 0);
    run_frame("fresh", -3, 2, 0, 4, 1, -1, -1);

    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("rand%0d", i),
                int'($urandom_range(400, 0)) - 200, int'($urandom_range(100, 0)) - 50,
                int'($urandom_range(400, 0)) - 200, int'($urandom_range(300, 0)),
                int'($urandom_range(1, 0)), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
